// File: rtl/ins_encoder.sv
// rtl/ins_encoder.sv - RISC-V style field-bundle to instruction-word encoder with program-load sequencing
//
// Purpose: accepts decoded field bundles during a program load, encodes them
// into 32-bit instruction words, and presents each word with its byte address
// to an instruction memory. Out-of-range immediates or invalid formats are
// replaced by a NOP (addi x0,x0,0) and flagged.
//
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   START               pulse that begins a program load (IDLE/DONE -> LOAD)
//   IN_VALID/IN_READY   input bundle handshake
//   FMT, OPCODE, RD, RS1, RS2, FUNC3, FUNC7, IMM, LAST   bundle fields
//   OUT_VALID/OUT_READY output word handshake
//   INS_OUT, WR_ADDR, ERR                 registered word, byte address, error tag
//   ERR_FLAG            sticky error flag for the current load
//   BUSY                high while loading

module ins_encoder #(
  parameter int          INS_WIDTH  = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [2:0]            FMT,
  input  logic [6:0]            OPCODE,
  input  logic [4:0]            RD,
  input  logic [4:0]            RS1,
  input  logic [4:0]            RS2,
  input  logic [2:0]            FUNC3,
  input  logic [6:0]            FUNC7,
  input  logic [31:0]           IMM,
  input  logic                  LAST,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [INS_WIDTH-1:0]  INS_OUT,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic                  ERR,
  output logic                  ERR_FLAG,
  output logic                  BUSY
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
  localparam logic [31:0]           NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic                    load_entry;
  logic                    last_q;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    accept;
  logic                    out_fire;
  logic [31:0]             enc;
  logic                    enc_err;
  logic                    fits_12, fits_sb, fits_uj;

  assign IN_READY = (state == S_LOAD) && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign out_fire = OUT_VALID && OUT_READY;
  assign BUSY     = (state == S_LOAD);

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_entry = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_nxt  = S_LOAD;
          load_entry = 1'b1;
        end
      end
      S_LOAD: begin
        // The load ends only once memory has taken the word tagged LAST.
        if (out_fire && last_q) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Signed range checks expressed as "upper bits are a sign extension".
  assign fits_12 = (IMM[31:11] == {21{IMM[11]}});
  assign fits_sb = (IMM[31:12] == {20{IMM[12]}}) && !IMM[0];
  assign fits_uj = (IMM[31:20] == {12{IMM[20]}}) && !IMM[0];

  always_comb begin
    enc     = NOP;
    enc_err = 1'b0;
    case (FMT)
      3'd0: enc = {FUNC7, RS2, RS1, FUNC3, RD, OPCODE};
      3'd1: begin
        enc     = {IMM[11:0], RS1, FUNC3, RD, OPCODE};
        enc_err = !fits_12;
      end
      3'd2: begin
        enc     = {IMM[11:5], RS2, RS1, FUNC3, IMM[4:0], OPCODE};
        enc_err = !fits_12;
      end
      3'd3: begin
        enc     = {IMM[12], IMM[10:5], RS2, RS1, FUNC3, IMM[4:1], IMM[11], OPCODE};
        enc_err = !fits_sb;
      end
      3'd4: begin
        enc     = {IMM[31:12], RD, OPCODE};
        enc_err = (IMM[11:0] != 12'd0);
      end
      3'd5: begin
        enc     = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE};
        enc_err = !fits_uj;
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc = NOP;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      INS_OUT   <= '0;
      ERR       <= 1'b0;
      ERR_FLAG  <= 1'b0;
      WR_ADDR   <= BASE;
      next_addr <= BASE;
      last_q    <= 1'b0;
    end else begin
      if (load_entry) begin
        next_addr <= BASE;
        ERR_FLAG  <= 1'b0;
      end
      // accept and load_entry are exclusive: accept needs state LOAD.
      if (accept) begin
        OUT_VALID <= 1'b1;
        INS_OUT   <= INS_WIDTH'(enc);
        ERR       <= enc_err;
        WR_ADDR   <= next_addr;
        last_q    <= LAST;
        next_addr <= next_addr + STEP;
        if (enc_err) ERR_FLAG <= 1'b1;
      end else if (out_fire) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// tb/tb_ins_encoder.sv - self-checking bench for ins_encoder
module tb_ins_encoder;

  logic        CLK = 1'b0;
  logic        RESET, START, IN_VALID, IN_READY, LAST, OUT_VALID, OUT_READY;
  logic [2:0]  FMT, FUNC3;
  logic [6:0]  OPCODE, FUNC7;
  logic [4:0]  RD, RS1, RS2;
  logic [31:0] IMM, INS_OUT;
  logic [3:0]  WR_ADDR;
  logic        ERR, ERR_FLAG, BUSY;

  always #5 CLK = ~CLK;

  ins_encoder #(.INS_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FMT(FMT), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2), .FUNC3(FUNC3),
    .FUNC7(FUNC7), .IMM(IMM), .LAST(LAST), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .INS_OUT(INS_OUT), .WR_ADDR(WR_ADDR), .ERR(ERR), .ERR_FLAG(ERR_FLAG), .BUSY(BUSY)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] ins;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic        err;
    int          addr;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input int unsigned fmt, op, rd, rs1, rs2, f3, f7,
                              input logic [31:0] imm, input logic [31:0] ins, input logic err);
    vec_t v;
    v.fmt = 3'(fmt); v.op = 7'(op); v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.f3 = 3'(f3); v.f7 = 7'(f7); v.imm = imm; v.ins = ins; v.err = err;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic last);
    FMT = v.fmt; OPCODE = v.op; RD = v.rd; RS1 = v.rs1; RS2 = v.rs2;
    FUNC3 = v.f3; FUNC7 = v.f7; IMM = v.imm; LAST = last; IN_VALID = 1'b1;
  endtask

  task automatic idle_in();
    IN_VALID = 1'b0;
    LAST     = 1'b0;
  endtask

  // Reference encoder: field placement by shift/mask arithmetic, range checks on signed integers.
  function automatic exp_t model(input vec_t v, input int addr);
    exp_t        e;
    int unsigned u = v.imm;
    int          s = $signed(v.imm);
    int unsigned r = 0;
    int unsigned regs_s = (32'(v.rs2) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12);
    int unsigned op = 32'(v.op);
    int unsigned rdf = 32'(v.rd) << 7;
    bit          ok = 1'b1;
    case (v.fmt)
      3'd0: r = (32'(v.f7) << 25) | regs_s | rdf | op;
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        r  = ((u & 32'hFFF) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) | rdf | op;
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        r  = (((u >> 5) & 32'h7F) << 25) | regs_s | ((u & 32'h1F) << 7) | op;
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        r  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | regs_s |
             (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | op;
      end
      3'd4: begin
        ok = ((u & 32'hFFF) == 0);
        r  = (u & 32'hFFFFF000) | rdf | op;
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        r  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
             (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | rdf | op;
      end
      default: ok = 1'b0;
    endcase
    e.ins  = ok ? r : 32'h13;
    e.err  = !ok;
    e.addr = addr % 16;
    return e;
  endfunction

  vec_t addi_v, sw_v, beq_v, lui_v, esb_v, ei_v;

  initial begin
    int          exp_addr;
    vec_t        rv;
    exp_t        e;
    logic [31:0] held_ins;
    logic [3:0]  held_addr;
    logic        held_err, holding;

    addi_v = mk(1, 7'b0010011, 1, 2, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFF10093, 1'b0);
    sw_v   = mk(2, 7'b0100011, 0, 2, 5, 2, 0, 32'd8,         32'h00512423, 1'b0);
    beq_v  = mk(3, 7'b1100011, 0, 1, 2, 0, 0, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
    lui_v  = mk(4, 7'b0110111, 3, 0, 0, 0, 0, 32'h1234_5000, 32'h123451B7, 1'b0);
    esb_v  = mk(3, 7'b1100011, 0, 1, 2, 0, 0, 32'd3,         32'h00000013, 1'b1);
    ei_v   = mk(1, 7'b0010011, 1, 2, 0, 0, 0, 32'd4096,      32'h00000013, 1'b1);

    vecs.push_back(addi_v);
    vecs.push_back(sw_v);
    vecs.push_back(beq_v);
    vecs.push_back(lui_v);
    vecs.push_back(esb_v);
    vecs.push_back(ei_v);
    vecs.push_back(mk(6, 7'h13, 1, 1, 1, 0, 0, 32'd0,          32'h00000013, 1'b1));
    vecs.push_back(mk(7, 7'h33, 1, 1, 1, 0, 0, 32'd0,          32'h00000013, 1'b1));
    vecs.push_back(mk(0, 7'h33, 1, 2, 3, 0, 7'h20, 32'hDEAD_BEEF, 32'h403100B3, 1'b0));
    vecs.push_back(mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'd8,          32'h008000EF, 1'b0));
    vecs.push_back(mk(4, 7'h37, 3, 0, 0, 0, 0, 32'h1234_5001, 32'h00000013, 1'b1));
    vecs.push_back(mk(1, 7'h13, 0, 0, 0, 0, 0, 32'hFFFF_F800, 32'h80000013, 1'b0));
    vecs.push_back(mk(1, 7'h13, 0, 0, 0, 0, 0, 32'hFFFF_F7FF, 32'h00000013, 1'b1));
    vecs.push_back(mk(2, 7'h23, 0, 0, 0, 0, 0, 32'd2047,       32'h7E000FA3, 1'b0));
    vecs.push_back(mk(2, 7'h23, 0, 0, 0, 0, 0, 32'd2048,       32'h00000013, 1'b1));
    vecs.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd4094,       32'h7E000FE3, 1'b0));
    vecs.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd4096,       32'h00000013, 1'b1));
    vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0, 32'd1048574,    32'h7FFFF06F, 1'b0));
    vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0, 32'hFFF0_0000, 32'h8000006F, 1'b0));
    vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0, 32'd1048576,    32'h00000013, 1'b1));
    vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0, 32'd3,          32'h00000013, 1'b1));

    RESET = 1'b1; START = 1'b0; OUT_READY = 1'b0; LAST = 1'b0; IN_VALID = 1'b0;
    drive(addi_v, 1'b0);
    IN_VALID = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    check("reset OUT_VALID", 32'(OUT_VALID), 32'd0);
    check("reset INS_OUT", INS_OUT, 32'd0);
    check("reset ERR", 32'(ERR), 32'd0);
    check("reset ERR_FLAG", 32'(ERR_FLAG), 32'd0);
    check("reset WR_ADDR", 32'(WR_ADDR), 32'd0);
    check("reset IN_READY", 32'(IN_READY), 32'd0);
    check("reset BUSY", 32'(BUSY), 32'd0);

    // A bundle offered in IDLE is refused.
    drive(addi_v, 1'b0);
    OUT_READY = 1'b1;
    #1 check("idle IN_READY", 32'(IN_READY), 32'd0);
    tick();
    check("idle no accept", 32'(OUT_VALID), 32'd0);
    idle_in();

    START = 1'b1;
    tick();
    START = 1'b0;
    check("start BUSY", 32'(BUSY), 32'd1);

    // addi, sw, beq back-to-back.
    drive(addi_v, 1'b0);
    #1 check("addi IN_READY", 32'(IN_READY), 32'd1);
    tick();
    check("addi OUT_VALID", 32'(OUT_VALID), 32'd1);
    check("addi INS_OUT", INS_OUT, 32'hFFF10093);
    check("addi WR_ADDR", 32'(WR_ADDR), 32'h0);
    check("addi ERR", 32'(ERR), 32'd0);
    drive(sw_v, 1'b0);
    #1 check("sw IN_READY", 32'(IN_READY), 32'd1);
    tick();
    check("sw INS_OUT", INS_OUT, 32'h00512423);
    check("sw WR_ADDR", 32'(WR_ADDR), 32'h4);
    drive(beq_v, 1'b0);
    #1 check("beq IN_READY", 32'(IN_READY), 32'd1);
    tick();
    check("beq INS_OUT", INS_OUT, 32'hFE208EE3);
    check("beq WR_ADDR", 32'(WR_ADDR), 32'h8);

    // lui then three cycles of backpressure.
    drive(lui_v, 1'b0);
    tick();
    check("lui INS_OUT", INS_OUT, 32'h123451B7);
    check("lui WR_ADDR", 32'(WR_ADDR), 32'hC);
    OUT_READY = 1'b0;
    drive(esb_v, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp IN_READY", 32'(IN_READY), 32'd0);
      tick();
      check("bp OUT_VALID", 32'(OUT_VALID), 32'd1);
      check("bp INS_OUT", INS_OUT, 32'h123451B7);
      check("bp WR_ADDR", 32'(WR_ADDR), 32'hC);
      check("bp ERR", 32'(ERR), 32'd0);
    end

    // Errors; the fifth word wraps to address 0 with ADDR_WIDTH=4.
    OUT_READY = 1'b1;
    #1 check("drain IN_READY", 32'(IN_READY), 32'd1);
    tick();
    check("err sb INS_OUT", INS_OUT, 32'h00000013);
    check("err sb ERR", 32'(ERR), 32'd1);
    check("wrap WR_ADDR", 32'(WR_ADDR), 32'h0);
    check("err sb ERR_FLAG", 32'(ERR_FLAG), 32'd1);
    drive(ei_v, 1'b1);
    tick();
    check("err i INS_OUT", INS_OUT, 32'h00000013);
    check("err i ERR", 32'(ERR), 32'd1);
    check("err i WR_ADDR", 32'(WR_ADDR), 32'h4);
    idle_in();
    tick();
    check("done OUT_VALID", 32'(OUT_VALID), 32'd0);
    check("done BUSY", 32'(BUSY), 32'd0);
    check("done IN_READY", 32'(IN_READY), 32'd0);
    check("done ERR_FLAG held", 32'(ERR_FLAG), 32'd1);
    drive(addi_v, 1'b0);
    tick();
    check("done no accept", 32'(OUT_VALID), 32'd0);
    idle_in();

    START = 1'b1;
    tick();
    START = 1'b0;
    check("restart BUSY", 32'(BUSY), 32'd1);
    check("restart ERR_FLAG", 32'(ERR_FLAG), 32'd0);

    // Table of encodings, one word at a time.
    exp_addr = 0;
    foreach (vecs[i]) begin
      drive(vecs[i], 1'b0);
      tick();
      check($sformatf("vec%0d INS_OUT", i), INS_OUT, vecs[i].ins);
      check($sformatf("vec%0d ERR", i), 32'(ERR), 32'(vecs[i].err));
      check($sformatf("vec%0d WR_ADDR", i), 32'(WR_ADDR), 32'(exp_addr % 16));
      exp_addr += 4;
    end
    idle_in();
    tick();
    check("table drain OUT_VALID", 32'(OUT_VALID), 32'd0);

    // Randomised traffic against the reference model.
    holding = 1'b0;
    held_ins = '0; held_addr = '0; held_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rv = mk($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, 32'd0, 32'd0, 1'b0);
      case ($urandom_range(0, 3))
        0: rv.imm = $urandom;
        1: rv.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: rv.imm = $urandom & 32'hFFFF_F000;
        default: rv.imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      drive(rv, 1'b0);
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      #1;
      if (holding) begin
        check("rand hold INS_OUT", INS_OUT, held_ins);
        check("rand hold WR_ADDR", 32'(WR_ADDR), 32'(held_addr));
        check("rand hold ERR", 32'(ERR), 32'(held_err));
      end
      holding = OUT_VALID && !OUT_READY;
      held_ins = INS_OUT; held_addr = WR_ADDR; held_err = ERR;
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("rand unexpected word", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rand INS_OUT", INS_OUT, e.ins);
          check("rand ERR", 32'(ERR), 32'(e.err));
          check("rand WR_ADDR", 32'(WR_ADDR), 32'(e.addr));
        end
      end
      if (IN_VALID && IN_READY) begin
        sb.push_back(model(rv, exp_addr));
        exp_addr += 4;
      end
      tick();
    end
    idle_in();
    OUT_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (OUT_VALID) begin
        if (sb.size() == 0) begin
          check("drain unexpected word", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("drain INS_OUT", INS_OUT, e.ins);
          check("drain WR_ADDR", 32'(WR_ADDR), 32'(e.addr));
        end
      end
      tick();
    end
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    // Reset mid-LOAD with an erroring word pending, colliding with START and a handshake.
    OUT_READY = 1'b0;
    drive(esb_v, 1'b0);
    tick();
    idle_in();
    check("pending OUT_VALID", 32'(OUT_VALID), 32'd1);
    check("pending ERR_FLAG", 32'(ERR_FLAG), 32'd1);
    RESET = 1'b1; START = 1'b1; OUT_READY = 1'b1;
    drive(addi_v, 1'b0);
    tick();
    RESET = 1'b0; START = 1'b0;
    idle_in();
    #1;
    check("rst OUT_VALID", 32'(OUT_VALID), 32'd0);
    check("rst INS_OUT", INS_OUT, 32'd0);
    check("rst ERR", 32'(ERR), 32'd0);
    check("rst ERR_FLAG", 32'(ERR_FLAG), 32'd0);
    check("rst WR_ADDR", 32'(WR_ADDR), 32'd0);
    check("rst IN_READY", 32'(IN_READY), 32'd0);
    check("rst BUSY", 32'(BUSY), 32'd0);

    // After reset the counter restarts at the base address.
    START = 1'b1;
    tick();
    START = 1'b0;
    drive(addi_v, 1'b0);
    tick();
    idle_in();
    check("post-rst WR_ADDR", 32'(WR_ADDR), 32'd0);
    check("post-rst INS_OUT", INS_OUT, 32'hFFF10093);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
